// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: IR/MDR/A/B/ALUOut datapath driven by a control FSM,
// sharing one req/ready memory port between instruction fetch and load/store.
module multicycle_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       pc,
   output logic              retire,
   output logic              illegal
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP
   } state_t;

   state_t      state, next_state;
   logic [31:0] ir, mdr, a, b, aluout;
   logic [31:0] rf [32];
   logic [31:0] addr_full;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] sext_imm, zext_imm, alu_r, imm_r;
   logic        funct_ok, taken;

   assign op       = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign funct    = ir[5:0];
   assign sext_imm = {{16{ir[15]}}, ir[15:0]};
   assign zext_imm = {16'h0000, ir[15:0]};
   assign taken    = (op == 6'h04) ? (a == b) : (a != b);
   assign mem_addr = addr_full[ADDR_W-1:0];

   always_comb begin
      alu_r    = a + b;
      funct_ok = 1'b1;
      case (funct)
         6'h20:   alu_r = a + b;
         6'h22:   alu_r = a - b;
         6'h24:   alu_r = a & b;
         6'h25:   alu_r = a | b;
         6'h2A:   alu_r = {31'b0, $signed(a) < $signed(b)};
         default: funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      case (op)
         6'h0C:   imm_r = a & zext_imm;
         6'h0D:   imm_r = a | zext_imm;
         default: imm_r = a + sext_imm;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= next_state;
   end

   // Memory outputs are forced low while reset is held so an in-flight store can never complete.
   always_comb begin
      next_state = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_full  = 32'h0;
      mem_wdata  = 32'h0;
      retire     = 1'b0;
      illegal    = 1'b0;
      if (reset) begin
         case (state)
            FETCH: begin
               mem_req   = 1'b1;
               addr_full = pc;
               if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
               case (op)
                  6'h23, 6'h2B:        next_state = MEMADR;
                  6'h04, 6'h05:        next_state = BRANCH;
                  6'h08, 6'h0C, 6'h0D: next_state = IMMEX;
                  6'h02:               next_state = JUMP;
                  6'h00: begin
                     if (funct_ok) next_state = EXEC;
                     else begin
                        next_state = FETCH;
                        illegal    = 1'b1;
                     end
                  end
                  default: begin
                     next_state = FETCH;
                     illegal    = 1'b1;
                  end
               endcase
            end
            MEMADR: next_state = (op == 6'h23) ? MEMRD : MEMWR;
            MEMRD: begin
               mem_req   = 1'b1;
               addr_full = aluout;
               if (mem_ready) next_state = MEMWB;
            end
            MEMWR: begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               addr_full = aluout;
               mem_wdata = b;
               if (mem_ready) begin
                  retire     = 1'b1;
                  next_state = FETCH;
               end
            end
            EXEC:  next_state = ALUWB;
            IMMEX: next_state = IMMWB;
            MEMWB, ALUWB, IMMWB, BRANCH, JUMP: begin
               retire     = 1'b1;
               next_state = FETCH;
            end
            default: next_state = FETCH;
         endcase
      end
   end

   // Register 0 is never written, so it keeps its reset value of zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc     <= RESET_PC;
         ir     <= 32'h0;
         mdr    <= 32'h0;
         a      <= 32'h0;
         b      <= 32'h0;
         aluout <= 32'h0;
         for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      end else begin
         case (state)
            FETCH: if (mem_ready) begin
               ir <= mem_rdata;
               pc <= pc + 32'd4;
            end
            DECODE: begin
               a      <= rf[rs];
               b      <= rf[rt];
               aluout <= pc + {sext_imm[29:0], 2'b00};
            end
            MEMADR: aluout <= a + sext_imm;
            MEMRD:  if (mem_ready) mdr <= mem_rdata;
            MEMWB:  if (rt != 5'd0) rf[rt] <= mdr;
            EXEC:   aluout <= alu_r;
            ALUWB:  if (rd != 5'd0) rf[rd] <= aluout;
            BRANCH: if (taken) pc <= aluout;
            IMMEX:  aluout <= imm_r;
            IMMWB:  if (rt != 5'd0) rf[rt] <= aluout;
            JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
            default: ;
         endcase
      end
   end

endmodule
